// File: rtl/r_type_ctrl.sv
// r_type_ctrl: multi-cycle sequencer for register-register (R-type) MIPS
// instructions. Each instruction runs IF -> ID -> EX -> WB (4 cycles).
// The IF cycle sends a read strobe to a synchronous ROM. The ID edge
// latches the returned word. The rs/rt/rd fields and the decoded ALU
// operation are presented through EX and WB. The register-file write
// strobe is issued in WB.
//
// Ports
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   Run        in   level enable for instruction sequencing
//   Inst_Data  in   ROM word, valid the cycle after Inst_Req
//   OF, ZF     in   overflow / zero flags from the ALU stage
//   PC         out  byte address of the current instruction
//   Inst_Req   out  ROM read strobe (IF only)
//   R_Addr_A/B out  rs / rt of the current instruction
//   W_Addr     out  rd of the current instruction
//   ALU_OP     out  decoded ALU operation
//   Write_Reg  out  register-file write enable (WB only)
//   Zero_Flag  out  ZF captured at the end of each WB
//   Illegal    out  sticky unsupported-instruction flag
//   Halted     out  high in HALT
//   Inst_Cnt   out  retired-instruction count
//   state_dbg  out  current FSM state, for checkers
//
// Handshake: the ROM has no ready/valid pair. Inst_Req is a one-cycle read
// strobe. The ROM returns Inst_Data in the following cycle, which is ID.
// The word is sampled at the edge that ends ID.
module r_type_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic [31:0] Inst_Data,
  input  logic        OF,
  input  logic        ZF,
  output logic [31:0] PC,
  output logic        Inst_Req,
  output logic [4:0]  R_Addr_A,
  output logic [4:0]  R_Addr_B,
  output logic [4:0]  W_Addr,
  output logic [2:0]  ALU_OP,
  output logic        Write_Reg,
  output logic        Zero_Flag,
  output logic        Illegal,
  output logic        Halted,
  output logic [15:0] Inst_Cnt,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_HALT  = 6'b111111;

  // The function returns {legal, alu_op}. Any word that is not a supported
  // R-type instruction returns legal = 0 and alu_op = 0.
  function automatic logic [3:0] decode(input logic [31:0] w);
    logic [3:0] r;
    r = 4'b0000;
    if (w[31:26] == OPC_RTYPE) begin
      case (w[5:0])
        6'b100100:           r = 4'b1000;  // and
        6'b100101:           r = 4'b1001;  // or
        6'b100110:           r = 4'b1010;  // xor
        6'b100111:           r = 4'b1011;  // nor
        6'b100000, 6'b100001: r = 4'b1100; // add / addu
        6'b100010, 6'b100011: r = 4'b1101; // sub / subu
        6'b101010:           r = 4'b1110;  // slt
        6'b000100:           r = 4'b1111;  // sllv
        default:             r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [4:0]  ra_q, ra_d, rb_q, rb_d, wa_q, wa_d;
  logic [2:0]  alu_q, alu_d;
  logic        zf_q, zf_d;
  logic        ill_q, ill_d;
  logic [15:0] cnt_q, cnt_d;

  logic [3:0]  id_dec;
  logic [3:0]  ir_dec;
  logic        exec_phase;
  logic        signed_op;
  logic        unused_shamt;

  assign id_dec = decode(Inst_Data);
  assign ir_dec = decode(ir_q);

  // The shamt field is not used by any supported operation.
  assign unused_shamt = ^ir_q[10:6];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      wa_q    <= '0;
      alu_q   <= '0;
      zf_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      wa_q    <= wa_d;
      alu_q   <= alu_d;
      zf_q    <= zf_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    wa_d    = wa_q;
    alu_d   = alu_q;
    zf_d    = zf_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_IF;
      S_IF:   state_d = S_ID;
      S_ID: begin
        ir_d = Inst_Data;
        pc_d = pc_q + 32'd4;
        if (Inst_Data[31:26] == OPC_HALT) begin
          state_d = S_HALT;
        end else begin
          state_d = S_EX;
          if (!id_dec[3]) ill_d = 1'b1;
        end
      end
      S_EX: begin
        state_d = S_WB;
        // Capture the fields that are live in EX/WB. The outputs then keep
        // these values while the FSM is outside EX/WB.
        ra_d  = ir_q[25:21];
        rb_d  = ir_q[20:16];
        wa_d  = ir_q[15:11];
        alu_d = ir_dec[2:0];
      end
      S_WB: begin
        zf_d    = ZF;
        cnt_d   = cnt_q + 16'd1;
        state_d = Run ? S_IF : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign exec_phase = (state_q == S_EX) || (state_q == S_WB);
  assign signed_op  = (ir_q[5:0] == 6'b100000) || (ir_q[5:0] == 6'b100010);

  assign PC        = pc_q;
  assign Inst_Req  = (state_q == S_IF);
  assign R_Addr_A  = exec_phase ? ir_q[25:21] : ra_q;
  assign R_Addr_B  = exec_phase ? ir_q[20:16] : rb_q;
  assign W_Addr    = exec_phase ? ir_q[15:11] : wa_q;
  assign ALU_OP    = exec_phase ? ir_dec[2:0] : alu_q;
  // This signal is decoded from the state register, so an asynchronous
  // reset drops it at once. Writes to $0 are suppressed. Signed add/sub
  // that overflowed are also suppressed.
  assign Write_Reg = (state_q == S_WB) && ir_dec[3] && (ir_q[15:11] != 5'd0)
                     && !(OF && signed_op);
  assign Zero_Flag = zf_q;
  assign Illegal   = ill_q;
  assign Halted    = (state_q == S_HALT);
  assign Inst_Cnt  = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: doc/r_type_ctrl.md
R_TYPE_CTRL -- requirements
Module: r_type_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports as follows (clock and reset first).
REQ-002 Clk  in  1  rising-edge clock for all state.
REQ-003 Reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 Run  in  1  level enable; starts or continues instruction sequencing.
REQ-005 Inst_Data  in  32  instruction word from the synchronous instruction ROM, valid in the cycle after Inst_Req.
REQ-006 OF  in  1  overflow flag from the register-file/ALU stage.
REQ-007 ZF  in  1  zero flag from the register-file/ALU stage.
REQ-008 PC  out  32  current instruction byte address, word-aligned.
REQ-009 Inst_Req  out  1  ROM read strobe.
REQ-010 R_Addr_A / R_Addr_B / W_Addr  out  5 each  rs / rt / rd fields of the latched instruction.
REQ-011 ALU_OP  out  3  decoded ALU operation.
REQ-012 Write_Reg  out  1  register-file write enable.
REQ-013 Zero_Flag  out  1  ZF registered at the end of each write-back.
REQ-014 Illegal  out  1  sticky: an unsupported instruction was seen.
REQ-015 Halted  out  1  high while in HALT.
REQ-016 Inst_Cnt  out  16  count of retired instructions.

Function
REQ-017 The FSM SHALL have six states: IDLE, IF, ID, EX, WB and HALT.
REQ-018 IDLE->IF when Run=1; otherwise hold IDLE.
REQ-019 IF: Inst_Req=1, PC presented; next state ID.
REQ-020 ID: IR latched from Inst_Data at the end of ID; PC<=PC+4 (32-bit wrap) at the same edge; next state EX, or HALT if IR opcode=6'b111111.
REQ-021 EX: rs/rt/rd/ALU_OP driven from IR and held stable through WB; next state WB.
REQ-022 WB: Write_Reg asserted for exactly this one cycle unless suppressed; Zero_Flag<=ZF and Inst_Cnt<=Inst_Cnt+1 (wrap at 16'hFFFF->0) at the end of WB; next state IF if Run=1, else IDLE.
REQ-023 Run deasserted mid-instruction SHALL NOT abort it; the instruction completes through WB, then the FSM enters IDLE.
REQ-024 HALT is absorbing until Reset; no ROM reads, no writes, PC frozen at the address after the halt word.
REQ-025 Decode (opcode 000000 only), funct->ALU_OP: 100100->000 AND; 100101->001 OR; 100110->010 XOR; 100111->011 NOR; 100000/100001->100 ADD; 100010/100011->101 SUB; 101010->110 SLT; 000100->111 SLLV.
REQ-026 Any other opcode (except 111111) or funct is illegal: Illegal<=1 at the end of ID, Write_Reg stays 0 in WB, and the instruction still retires (counted).
REQ-027 Write_Reg SHALL be suppressed in WB when rd=0.
REQ-028 Write_Reg SHALL be suppressed in WB when OF=1 and funct is 100000 or 100010 (signed add/sub); unsigned variants write regardless of OF.
REQ-029 Outside EX/WB the address outputs and ALU_OP SHALL retain their last values; Write_Reg and Inst_Req SHALL be 0 outside WB and IF respectively.
REQ-030 Latency: 4 cycles per instruction (IF, ID, EX, WB); back-to-back instructions with Run held high give one Write_Reg pulse every 4 cycles.

Reset
REQ-031 On Reset=1 (asynchronous), the block SHALL take these values: state=IDLE, PC=0, IR=0, R_Addr_A=R_Addr_B=W_Addr=0, ALU_OP=0, Write_Reg=0, Inst_Req=0, Zero_Flag=0, Illegal=0, Halted=0, Inst_Cnt=0.
REQ-032 Reset asserted in any state, including mid-WB, SHALL drop Write_Reg within the same cycle without waiting for a clock edge.
REQ-033 Operation SHALL resume from IDLE on the first rising edge after Reset deasserts.

Verification
REQ-034 The bench SHALL cover: ROM[0]=0x00221820 (add $3,$1,$2), Run=1, OF=0 -> Inst_Req at cycle 1, then R_Addr_A=1, R_Addr_B=2, W_Addr=3, ALU_OP=100, Write_Reg pulse in cycle 4, PC=4, Inst_Cnt=1.
REQ-035 The bench SHALL cover: same add with OF=1 in WB -> no Write_Reg pulse, Inst_Cnt still increments; addu (0x00221821) with OF=1 -> Write_Reg pulses.
REQ-036 The bench SHALL cover: 0x00220024 (and $0,$1,$2) -> ALU_OP=000, no Write_Reg; 0x8C010000 (lw) -> Illegal=1, no write, PC advances.
REQ-037 The bench SHALL cover: 0xFC000000 at address 8 -> Halted=1, PC=12, no further Inst_Req even with Run=1; Reset -> PC=0, Halted=0.
REQ-038 The bench SHALL cover: Run dropped during EX -> WB completes, FSM enters IDLE; Reset pulsed mid-WB -> Write_Reg falls immediately and all outputs reach their reset values.
